mig_seq_evaluator: RTL

- Sequential evaluator for majority-inverter-graph (MIG) networks over 7 inputs x0..x6.
- A single shared MAJ3 unit is time-multiplexed across up to MAX_NODES programmed nodes, one node per cycle.
- Single-point mode returns one output bit. Sweep mode enumerates all 128 input combinations and returns the full truth table plus its popcount, for function classification.
- Sits between the host/config bus and the classification logic.

---
 rtl/mig_seq_evaluator.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mig_seq_evaluator.sv
// Sequential MIG evaluator: one shared MAJ3 unit steps through a programmed node list,
// either for a single input point or for a full 128-point truth-table sweep.
module mig_seq_evaluator #(
    parameter int unsigned MAX_NODES = 8,
    parameter int unsigned SEL_W     = 4,
    parameter int unsigned AW        = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [AW-1:0]            cfg_addr,
    input  logic [3*(SEL_W+1)-1:0]   cfg_data,
    input  logic [AW:0]              num_nodes,
    input  logic                     out_inv,
    input  logic                     start,
    input  logic                     sweep,
    input  logic [6:0]               x,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     out,
    output logic [127:0]             tt,
    output logic [7:0]               tt_ones
);

    localparam int unsigned FW = SEL_W + 1;
    localparam int unsigned WW = 3 * FW;

    typedef enum logic [1:0] {StIdle, StEval, StFin} state_e;

    state_e                          state_q, state_d;
    logic [MAX_NODES-1:0][WW-1:0]    prog_q, prog_d;
    logic [MAX_NODES-1:0]            res_q, res_d;
    logic [AW-1:0]                   idx_q, idx_d;
    logic [AW:0]                     n_q, n_d;
    logic                            inv_q, inv_d;
    logic                            sweep_q, sweep_d;
    logic [6:0]                      x_q, x_d;
    logic [7:0]                      cnt_q, cnt_d;
    logic                            err_q, err_d;
    logic                            out_q, out_d;
    logic [127:0]                    tt_q, tt_d;
    logic [7:0]                      tt_ones_q, tt_ones_d;

    logic [WW-1:0] cur_word;
    logic          op_a, op_b, op_c, maj, fin, last;

    // Unmatched selects (const 0 slot, out-of-range node) fall through to 0.
    function automatic logic operand(input logic [FW-1:0] f, input logic [6:0] xv,
                                     input logic [MAX_NODES-1:0] res);
        logic v;
        v = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (f[SEL_W-1:0] == SEL_W'(i)) v = xv[i];
        end
        for (int k = 0; k < MAX_NODES; k++) begin
            if (f[SEL_W-1:0] == SEL_W'(8 + k)) v = res[k];
        end
        return v ^ f[SEL_W];
    endfunction

    always_comb begin
        cur_word = prog_q[idx_q];
        op_a     = operand(cur_word[WW-1 -: FW], x_q, res_q);
        op_b     = operand(cur_word[2*FW-1 -: FW], x_q, res_q);
        op_c     = operand(cur_word[FW-1:0], x_q, res_q);
        maj      = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
        fin      = maj ^ inv_q;
        last     = ({1'b0, idx_q} == (n_q - (AW+1)'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) begin
                if (num_nodes == '0 || num_nodes > (AW+1)'(MAX_NODES)) state_d = StFin;
                else                                                  state_d = StEval;
            end
            StEval: if (last && (!sweep_q || x_q == 7'h7f)) state_d = StFin;
            StFin:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        prog_d    = prog_q;
        res_d     = res_q;
        idx_d     = idx_q;
        n_d       = n_q;
        inv_d     = inv_q;
        sweep_d   = sweep_q;
        x_d       = x_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        out_d     = out_q;
        tt_d      = tt_q;
        tt_ones_d = tt_ones_q;

        if (state_q == StIdle && cfg_we && {1'b0, cfg_addr} < (AW+1)'(MAX_NODES)) begin
            prog_d[cfg_addr] = cfg_data;
        end

        if (state_q == StIdle && start) begin
            if (num_nodes == '0 || num_nodes > (AW+1)'(MAX_NODES)) begin
                err_d = 1'b1;
                out_d = 1'b0;
            end else begin
                n_d     = num_nodes;
                inv_d   = out_inv;
                sweep_d = sweep;
                x_d     = sweep ? 7'h00 : x;
                res_d   = '0;
                idx_d   = '0;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
        end else if (state_q == StEval) begin
            res_d[idx_q] = maj;
            if (!last) begin
                idx_d = idx_q + AW'(1);
            end else if (!sweep_q) begin
                out_d = fin;
            end else begin
                tt_d[x_q] = fin;
                cnt_d     = cnt_q + 8'(fin);
                if (x_q == 7'h7f) begin
                    tt_ones_d = cnt_q + 8'(fin);
                end else begin
                    x_d   = x_q + 7'd1;
                    idx_d = '0;
                    res_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_q    <= '0;
            res_q     <= '0;
            idx_q     <= '0;
            n_q       <= '0;
            inv_q     <= 1'b0;
            sweep_q   <= 1'b0;
            x_q       <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            out_q     <= 1'b0;
            tt_q      <= '0;
            tt_ones_q <= '0;
        end else begin
            prog_q    <= prog_d;
            res_q     <= res_d;
            idx_q     <= idx_d;
            n_q       <= n_d;
            inv_q     <= inv_d;
            sweep_q   <= sweep_d;
            x_q       <= x_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            out_q     <= out_d;
            tt_q      <= tt_d;
            tt_ones_q <= tt_ones_d;
        end
    end

    always_comb begin
        busy    = (state_q == StEval);
        done    = (state_q == StFin);
        err     = err_q;
        out     = out_q;
        tt      = tt_q;
        tt_ones = tt_ones_q;
    end

endmodule
